// File: rtl/mux_select_arbiter_pkg.sv
// Shared encodings for the 2:1 steering-mux arbiter: FSM states and requester indices.
package mux_select_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    function automatic state_t gnt_state(input logic idx);
        return idx ? GNT1 : GNT0;
    endfunction

endpackage

// File: rtl/mux_select_arbiter_if.sv
// Request/grant bundle between the two requesters and the mux_select_arbiter.
interface mux_select_arbiter_if;
    logic [1:0] req;
    logic [1:0] grant;
    logic       select;
    logic       busy;

    modport master (output req, input grant, input select, input busy);
    modport slave  (input req, output grant, output select, output busy);
endinterface

// File: rtl/mux_select_arbiter_burst_counter.sv
// arb_burst_counter: counts consecutive grant cycles of the current owner, saturating at MAX_BURST.
module arb_burst_counter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic clear,
    input  logic en,
    output logic at_limit
);

    logic [CNT_W-1:0] cnt;

    // load wins over clear: a grant entry always starts a fresh burst at 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (clear) begin
            cnt <= '0;
        end else if (en && !at_limit) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_limit = (cnt == CNT_W'(MAX_BURST));

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin owner of the shared one-bit 2:1 steering mux; select is registered and moves only on grant entry.
// Optional burst limit enabled by defining MUX_ARB_BURST_LIMIT_EN.
module mux_select_arbiter
    import mux_select_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mux_select_arbiter_if.slave   bus
);

    if (MAX_BURST < 2 || MAX_BURST > 7 || (1 << CNT_W) <= MAX_BURST) begin : g_bad_cfg
        $error("mux_select_arbiter: MAX_BURST must be 2..7 and fit in CNT_W bits");
    end

    state_t     state, next_state;
    logic       last_q;
    logic       select_q;
    logic       busy_q;
    logic [1:0] grant_q;
    logic       r0, r1;
    logic       at_limit;
    logic       entry;
    logic       new_owner;

    assign r0 = bus.req[REQ0];
    assign r1 = bus.req[REQ1];

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                case ({r1, r0})
                    2'b01:   next_state = GNT0;
                    2'b10:   next_state = GNT1;
                    2'b11:   next_state = gnt_state(~last_q);
                    default: next_state = IDLE;
                endcase
            end
            GNT0: begin
                if (r0) begin
                    if (at_limit && r1) next_state = GNT1;
                end else begin
                    next_state = r1 ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (r1) begin
                    if (at_limit && r0) next_state = GNT0;
                end else begin
                    next_state = r0 ? GNT0 : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // a handover between owners is also an entry, so it restarts the burst
    assign entry     = (next_state != state) && (next_state != IDLE);
    assign new_owner = (next_state == GNT1);

`ifdef MUX_ARB_BURST_LIMIT_EN
    arb_burst_counter #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_burst_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (entry),
        .clear    (next_state == IDLE),
        .en       ((next_state == state) && (state != IDLE)),
        .at_limit (at_limit)
    );
`else
    assign at_limit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant_q  <= 2'b00;
            busy_q   <= 1'b0;
            last_q   <= 1'b1;
            select_q <= 1'b0;
        end else begin
            state    <= next_state;
            grant_q  <= {next_state == GNT1, next_state == GNT0};
            busy_q   <= (next_state != IDLE);
            if (entry) begin
                last_q   <= new_owner;
                select_q <= new_owner;
            end
        end
    end

    assign bus.grant  = grant_q;
    assign bus.select = select_q;
    assign bus.busy   = busy_q;

endmodule
